countdown_timer: RTL

Consumes the BCD hhmmss value produced by the timer-setting block and counts it down once per second to 00:00:00, then raises an alarm for a fixed number of seconds. Sits between the setting block (source of `intended_set_timer`) and the seven-segment display mux. It supplies the live countdown value plus run/pause/expired status. Contains its own 1 Hz prescaler so it can be simulated quickly with a small divider.

---
 rtl/countdown_timer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss countdown timer with built-in seconds prescaler and timed alarm.
// Counts a loaded value down to zero once per TICK_DIV clocks, then holds an alarm.
module countdown_timer #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int ALARM_SECONDS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] intended_set_timer,
    input  logic        start_pause,
    input  logic        clear,
    output logic [23:0] countdown_display,
    output logic [1:0]  timer_state,
    output logic        alarm,
    output logic        load_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_SECONDS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECONDS - 1);

    state_t        state_reg;
    logic [23:0]   count_reg;
    logic [PW-1:0] presc_reg;
    logic [AW-1:0] alarm_cnt_reg;
    logic          alarm_reg;
    logic          load_error_reg;
    logic          start_prev_reg;

    logic [5:0]    digit_ok;
    logic          value_ok;
    logic [23:0]   count_dec;
    logic          start_edge;
    logic          load_window;
    logic          load_accept;
    logic          load_reject;
    logic          presc_wrap;

    // Tens-of-minutes and tens-of-seconds digits (indices 3 and 1) stop at 5.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = (gi == 1 || gi == 3) ? 4'd5 : 4'd9;
            assign digit_ok[gi] = (intended_set_timer[4*gi +: 4] <= LIMIT);
        end
    endgenerate

    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign value_ok    = &digit_ok;
    assign count_dec   = bcd_dec(count_reg);
    assign start_edge  = start_pause & ~start_prev_reg;
    assign load_window = (state_reg == IDLE) || (state_reg == PAUSED);
    assign load_accept = load & load_window & value_ok;
    assign load_reject = load & load_window & ~value_ok;
    assign presc_wrap  = (presc_reg == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            presc_reg      <= '0;
            alarm_cnt_reg  <= '0;
            alarm_reg      <= 1'b0;
            load_error_reg <= 1'b0;
            start_prev_reg <= 1'b0;
        end else begin
            start_prev_reg <= start_pause;
            load_error_reg <= 1'b0;
            if (clear) begin
                state_reg     <= IDLE;
                count_reg     <= '0;
                presc_reg     <= '0;
                alarm_cnt_reg <= '0;
                alarm_reg     <= 1'b0;
            end else if (load_accept) begin
                // An accepted load swallows any start edge in the same cycle.
                count_reg <= intended_set_timer;
                presc_reg <= '0;
            end else begin
                if (load_reject) begin
                    load_error_reg <= 1'b1;
                end
                case (state_reg)
                    IDLE: begin
                        if (start_edge && count_reg != 24'd0) begin
                            state_reg <= RUNNING;
                            presc_reg <= '0;
                        end
                    end
                    RUNNING: begin
                        // The pause cycle itself still counts as running time.
                        if (presc_wrap) begin
                            presc_reg <= '0;
                            count_reg <= count_dec;
                            if (count_dec == 24'd0) begin
                                state_reg     <= EXPIRED;
                                alarm_reg     <= 1'b1;
                                alarm_cnt_reg <= '0;
                            end else if (start_edge) begin
                                state_reg <= PAUSED;
                            end
                        end else begin
                            presc_reg <= presc_reg + 1'b1;
                            if (start_edge) begin
                                state_reg <= PAUSED;
                            end
                        end
                    end
                    PAUSED: begin
                        if (start_edge) begin
                            state_reg <= RUNNING;
                        end
                    end
                    EXPIRED: begin
                        presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
                        if (start_edge) begin
                            state_reg <= IDLE;
                            alarm_reg <= 1'b0;
                            presc_reg <= '0;
                        end else if (presc_wrap) begin
                            if (alarm_cnt_reg == ALARM_LAST) begin
                                state_reg <= IDLE;
                                alarm_reg <= 1'b0;
                            end else begin
                                alarm_cnt_reg <= alarm_cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign countdown_display = count_reg;
    assign timer_state       = state_reg;
    assign alarm             = alarm_reg;
    assign load_error        = load_error_reg;

endmodule
